// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/stall/halt controls from DECODE, debug load port,
// and the IF/ID outputs handed back to DECODE and the debug unit.
interface fetch_stage_if #(
    parameter int NB_DATA    = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_enable;
    logic                  i_pc_write;
    logic                  i_IF_ID_write;
    logic                  i_branch_or_jump;
    logic [1:0]            i_pc_src;
    logic [ADDR_WIDTH-1:0] i_addr_branch;
    logic [ADDR_WIDTH-1:0] i_addr_jump;
    logic [ADDR_WIDTH-1:0] i_addr_register;
    logic                  i_halt;
    logic                  i_inst_load_en;
    logic [ADDR_WIDTH-1:0] i_inst_load_addr;
    logic [NB_DATA-1:0]    i_inst_load_data;
    logic [NB_DATA-1:0]    o_instruction;
    logic [NB_DATA-1:0]    o_pc;
    logic [NB_DATA-1:0]    o_pc_current;
    logic                  o_halted;

    modport master (
        output i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
               i_addr_branch, i_addr_jump, i_addr_register, i_halt,
               i_inst_load_en, i_inst_load_addr, i_inst_load_data,
        input  o_instruction, o_pc, o_pc_current, o_halted
    );

    modport slave (
        input  i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
               i_addr_branch, i_addr_jump, i_addr_register, i_halt,
               i_inst_load_en, i_inst_load_addr, i_inst_load_data,
        output o_instruction, o_pc, o_pc_current, o_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, debug-loadable instruction memory and the
// IF/ID register, steered by DECODE's redirect, stall and halt controls.
module fetch_stage #(
    parameter int NB_DATA    = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic          i_clock,
    input  logic          i_reset,
    fetch_stage_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [NB_DATA-1:0] r_mem [0:DEPTH-1];
    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_ifid_instr;
    logic [NB_DATA-1:0] r_ifid_pc;
    logic               r_halted;

    logic [NB_DATA-1:0] w_fetch_word;
    logic [NB_DATA-1:0] w_pc_plus1;
    logic [NB_DATA-1:0] w_target;
    logic [NB_DATA-1:0] w_pc_next;
    logic [NB_DATA-1:0] w_ifid_instr_next;
    logic [NB_DATA-1:0] w_ifid_pc_next;
    logic               w_halted_next;

    assign w_fetch_word = r_mem[r_pc[ADDR_WIDTH-1:0]];
    assign w_pc_plus1   = r_pc + NB_DATA'(1);

    // Debug write port; non-blocking write gives read-before-write against the fetch
    always_ff @(posedge i_clock) begin
        if (i_reset && bus.i_inst_load_en) begin
            r_mem[bus.i_inst_load_addr] <= bus.i_inst_load_data;
        end
    end

    // Redirect target mux, zero-extended from the word-address width
    always_comb begin
        w_target = r_pc;
        case (bus.i_pc_src)
            2'b01:   w_target = {{(NB_DATA-ADDR_WIDTH){1'b0}}, bus.i_addr_branch};
            2'b10:   w_target = {{(NB_DATA-ADDR_WIDTH){1'b0}}, bus.i_addr_jump};
            2'b11:   w_target = {{(NB_DATA-ADDR_WIDTH){1'b0}}, bus.i_addr_register};
            default: w_target = w_pc_plus1;
        endcase
    end

    // Next-state selection in priority order: freeze, halt, stall, redirect, sequential
    always_comb begin
        w_pc_next         = r_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc_next    = r_ifid_pc;
        w_halted_next     = r_halted;
        if (r_halted || !bus.i_enable) begin
            w_pc_next = r_pc;
        end else if (bus.i_halt) begin
            w_halted_next     = 1'b1;
            w_ifid_instr_next = {NB_DATA{1'b0}};
            w_ifid_pc_next    = {NB_DATA{1'b0}};
        end else if (!bus.i_pc_write) begin
            // A redirect arriving during a stall is dropped; DECODE re-issues it
            if (bus.i_IF_ID_write) begin
                w_ifid_instr_next = w_fetch_word;
                w_ifid_pc_next    = w_pc_plus1;
            end else begin
                w_ifid_instr_next = r_ifid_instr;
            end
        end else if (bus.i_branch_or_jump && (bus.i_pc_src != 2'b00)) begin
            w_pc_next         = w_target;
            w_ifid_instr_next = {NB_DATA{1'b0}};
            w_ifid_pc_next    = {NB_DATA{1'b0}};
        end else begin
            w_pc_next = w_pc_plus1;
            if (bus.i_IF_ID_write) begin
                w_ifid_instr_next = w_fetch_word;
                w_ifid_pc_next    = w_pc_plus1;
            end else begin
                w_ifid_instr_next = r_ifid_instr;
            end
        end
    end

    // PC, IF/ID and sticky halt registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_pc         <= {NB_DATA{1'b0}};
            r_ifid_instr <= {NB_DATA{1'b0}};
            r_ifid_pc    <= {NB_DATA{1'b0}};
            r_halted     <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_halted     <= w_halted_next;
        end
    end

    assign bus.o_instruction = r_ifid_instr;
    assign bus.o_pc          = r_ifid_pc;
    assign bus.o_pc_current  = r_pc;
    assign bus.o_halted      = r_halted;
endmodule
